// File: rtl/point_weights_rd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// point_weights_rd_ctrl_pkg
// Shared constants and the controller state encoding for the pointwise
// (1x1) weight memory sequencer of a bneck stage.
//   DATA_WIDTH : weight element width
//   ROW_ELEMS  : weights per memory row (16x16)
//   HEIGHT     : memory depth in rows
//   IDX_W      : row index width
//   TILE_W     : tile counter width
//   PW_ROW_W   : bits per memory row
// ---------------------------------------------------------------------------
package point_weights_rd_ctrl_pkg;

    localparam int DATA_WIDTH = 14;
    localparam int ROW_ELEMS  = 256;
    localparam int HEIGHT     = 938;
    localparam int IDX_W      = 10;
    localparam int TILE_W     = 6;
    localparam int PW_ROW_W   = DATA_WIDTH * ROW_ELEMS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } pw_state_e;

endpackage

// File: rtl/point_weights_rd_ctrl_tile_counter.sv
// ---------------------------------------------------------------------------
// pw_tile_counter
// Nested input/output tile counter for the layer sweep. Rows are visited
// out-major, in-minor, so the memory cursor simply increments by one per
// step while (i, o) track the position inside the tile grid.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   load, base     : restart at row `base` with i = o = 0
//   in_tiles       : input tiles per output tile (inner loop length)
//   out_tiles      : output tiles (outer loop length)
//   step           : advance to the next row
//   cursor         : current row address
//   in_idx/out_idx : current (i, o)
//   first/last     : i is the first / last input tile
//   final_row      : current row is the last row of the sweep
// ---------------------------------------------------------------------------
module pw_tile_counter #(
    parameter int IDX_W  = 10,
    parameter int TILE_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [IDX_W-1:0]  base,
    input  logic [TILE_W-1:0] in_tiles,
    input  logic [TILE_W-1:0] out_tiles,
    input  logic              step,
    output logic [IDX_W-1:0]  cursor,
    output logic [TILE_W-1:0] in_idx,
    output logic [TILE_W-1:0] out_idx,
    output logic              first,
    output logic              last,
    output logic              final_row
);

    logic [IDX_W-1:0]  cursor_q;
    logic [TILE_W-1:0] i_q;
    logic [TILE_W-1:0] o_q;

    assign cursor    = cursor_q;
    assign in_idx    = i_q;
    assign out_idx   = o_q;
    assign first     = (i_q == '0);
    assign last      = (i_q == in_tiles - TILE_W'(1));
    assign final_row = last && (o_q == out_tiles - TILE_W'(1));

    // The cursor is frozen on the final row so it never walks past the
    // last legal address of the sweep (and therefore never past HEIGHT-1).
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_q <= '0;
            i_q      <= '0;
            o_q      <= '0;
        end else if (load) begin
            cursor_q <= base;
            i_q      <= '0;
            o_q      <= '0;
        end else if (step && !final_row) begin
            cursor_q <= cursor_q + IDX_W'(1);
            if (last) begin
                i_q <= '0;
                o_q <= o_q + TILE_W'(1);
            end else begin
                i_q <= i_q + TILE_W'(1);
            end
        end
    end

endmodule

// File: rtl/point_weights_rd_ctrl.sv
// ---------------------------------------------------------------------------
// point_weights_rd_ctrl
// Sequencer/arbiter for the 1x1 pointwise weight memory. While idle it
// services the weight-load port; on start it validates the layer config and
// streams rows base .. base+in*out-1 to the PE array under valid/ready.
// The memory has a 1-cycle synchronous read and holds data_out while
// mem_rd=0, so w_valid/tags qualify data_out directly.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, cfg_*             : sweep request and layer config (sampled in idle)
//   busy, done, err          : sweep status; done/err are one-cycle pulses
//   ld_valid/ld_ready        : load handshake, ld_index/ld_data row to write
//   mem_en/rd/wr/index       : memory control, mem_data_in = ld_data
//   w_valid/w_ready          : row handshake toward the PE array
//   w_first/w_last/w_out_tile: tags of the row currently on data_out
// ---------------------------------------------------------------------------
module point_weights_rd_ctrl
    import point_weights_rd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = point_weights_rd_ctrl_pkg::DATA_WIDTH,
    parameter int ROW_ELEMS  = point_weights_rd_ctrl_pkg::ROW_ELEMS,
    parameter int HEIGHT     = point_weights_rd_ctrl_pkg::HEIGHT,
    parameter int IDX_W      = point_weights_rd_ctrl_pkg::IDX_W,
    parameter int TILE_W     = point_weights_rd_ctrl_pkg::TILE_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [IDX_W-1:0]                cfg_base,
    input  logic [TILE_W-1:0]               cfg_in_tiles,
    input  logic [TILE_W-1:0]               cfg_out_tiles,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    input  logic                            ld_valid,
    output logic                            ld_ready,
    input  logic [IDX_W-1:0]                ld_index,
    input  logic [DATA_WIDTH*ROW_ELEMS-1:0] ld_data,
    output logic                            mem_en,
    output logic                            mem_rd,
    output logic                            mem_wr,
    output logic [IDX_W-1:0]                mem_index,
    output logic [DATA_WIDTH*ROW_ELEMS-1:0] mem_data_in,
    output logic                            w_valid,
    input  logic                            w_ready,
    output logic                            w_first,
    output logic                            w_last,
    output logic [TILE_W-1:0]               w_out_tile
);

    localparam int PROD_W = 2 * TILE_W;
    // Wide enough for base + N without wrap.
    localparam int SUM_W  = ((PROD_W > IDX_W) ? PROD_W : IDX_W) + 1;

    pw_state_e         state_q, state_d;
    logic [IDX_W-1:0]  base_q;
    logic [TILE_W-1:0] in_q, out_q;
    logic [PROD_W-1:0] rows_left_q;
    logic [IDX_W-1:0]  last_index_q;
    logic              w_valid_q, w_first_q, w_last_q, done_q;
    logic [TILE_W-1:0] w_out_tile_q;

    logic [PROD_W-1:0] n_rows;
    logic [SUM_W-1:0]  end_row;
    logic              cfg_bad;
    logic              issue;
    logic              handshake;
    logic              sweep_load;

    logic [IDX_W-1:0]  cursor;
    logic [TILE_W-1:0] in_idx, out_idx;
    logic              cnt_first, cnt_last, cnt_final;

    assign n_rows     = PROD_W'(in_q) * PROD_W'(out_q);
    assign end_row    = SUM_W'(base_q) + SUM_W'(n_rows);
    assign cfg_bad    = (in_q == '0) || (out_q == '0) || (end_row > SUM_W'(HEIGHT));
    // A new row may be fetched when the output slot is empty or being drained
    // this very cycle; this gives 1 row/cycle with w_ready held high.
    assign issue      = (state_q == ST_RUN) && (rows_left_q != '0) && (!w_valid_q || w_ready);
    assign handshake  = w_valid_q && w_ready;
    assign sweep_load = (state_q == ST_IDLE) && start;

    assign mem_data_in = ld_data;
    assign w_valid     = w_valid_q;
    assign w_first     = w_first_q;
    assign w_last      = w_last_q;
    assign w_out_tile  = w_out_tile_q;
    assign done        = done_q;

    pw_tile_counter #(
        .IDX_W  (IDX_W),
        .TILE_W (TILE_W)
    ) u_tile_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (sweep_load),
        .base      (cfg_base),
        .in_tiles  (in_q),
        .out_tiles (out_q),
        .step      (issue),
        .cursor    (cursor),
        .in_idx    (in_idx),
        .out_idx   (out_idx),
        .first     (cnt_first),
        .last      (cnt_last),
        .final_row (cnt_final)
    );

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        err       = 1'b0;
        ld_ready  = 1'b0;
        mem_en    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_index = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CHECK;
                end else if (ld_valid) begin
                    // Out-of-range loads are acknowledged but dropped.
                    ld_ready  = 1'b1;
                    mem_en    = 1'b1;
                    mem_wr    = ({1'b0, ld_index} < (IDX_W+1)'(HEIGHT));
                    mem_index = ld_index;
                end
            end
            ST_CHECK: begin
                busy    = 1'b1;
                err     = cfg_bad;
                state_d = cfg_bad ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                // Hold the last issued address so it is stable during stalls.
                mem_index = last_index_q;
                if (issue) begin
                    mem_en    = 1'b1;
                    mem_rd    = 1'b1;
                    mem_index = cursor;
                    if (rows_left_q == PROD_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                busy      = 1'b1;
                mem_index = last_index_q;
                if (handshake) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            in_q         <= '0;
            out_q        <= '0;
            rows_left_q  <= '0;
            last_index_q <= '0;
            w_valid_q    <= 1'b0;
            w_first_q    <= 1'b0;
            w_last_q     <= 1'b0;
            w_out_tile_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ST_DRAIN) && handshake;

            if (sweep_load) begin
                base_q <= cfg_base;
                in_q   <= cfg_in_tiles;
                out_q  <= cfg_out_tiles;
            end

            if (state_q == ST_CHECK) begin
                rows_left_q <= n_rows;
            end else if (issue) begin
                rows_left_q <= rows_left_q - PROD_W'(1);
            end

            // A fresh issue refills the slot even when the old row is being
            // consumed; otherwise a consumed row empties it.
            if (issue) begin
                w_valid_q    <= 1'b1;
                w_first_q    <= cnt_first;
                w_last_q     <= cnt_last;
                w_out_tile_q <= out_idx;
                last_index_q <= cursor;
            end else if (w_ready) begin
                w_valid_q <= 1'b0;
            end
        end
    end

    // in_idx and cnt_final are observable on the counter for debug; the
    // controller relies on rows_left for termination.
    logic unused_cnt;
    assign unused_cnt = ^{in_idx, cnt_final};

endmodule

// File: tb/tb_point_weights_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_point_weights_rd_ctrl
// Directed + randomized bench for point_weights_rd_ctrl. A behavioural weight
// memory is attached to the mem_* pins; the expected row stream of a sweep is
// derived from the loop nest o = 0..out-1, i = 0..in-1, row = base+o*in+i and
// the contents the bench itself loaded.
// ---------------------------------------------------------------------------
module tb_point_weights_rd_ctrl;
    import point_weights_rd_ctrl_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [IDX_W-1:0]    cfg_base;
    logic [TILE_W-1:0]   cfg_in_tiles, cfg_out_tiles;
    logic                busy, done, err;
    logic                ld_valid, ld_ready;
    logic [IDX_W-1:0]    ld_index;
    logic [PW_ROW_W-1:0] ld_data;
    logic                mem_en, mem_rd, mem_wr;
    logic [IDX_W-1:0]    mem_index;
    logic [PW_ROW_W-1:0] mem_data_in;
    logic                w_valid, w_ready, w_first, w_last;
    logic [TILE_W-1:0]   w_out_tile;

    always #5 clk = ~clk;

    point_weights_rd_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_base     (cfg_base),
        .cfg_in_tiles (cfg_in_tiles),
        .cfg_out_tiles(cfg_out_tiles),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_index     (ld_index),
        .ld_data      (ld_data),
        .mem_en       (mem_en),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_index    (mem_index),
        .mem_data_in  (mem_data_in),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_first      (w_first),
        .w_last       (w_last),
        .w_out_tile   (w_out_tile)
    );

    // Behavioural synchronous memory, 1-cycle read, holds data_out otherwise.
    logic [PW_ROW_W-1:0] mem_arr [HEIGHT];
    logic [PW_ROW_W-1:0] mem_q;
    always @(posedge clk) begin
        if (mem_en && mem_wr && (int'(mem_index) < HEIGHT)) mem_arr[mem_index] <= mem_data_in;
        if (mem_en && mem_rd && (int'(mem_index) < HEIGHT)) mem_q <= mem_arr[mem_index];
    end

    typedef struct {
        int row;
        bit first;
        bit last;
        int o;
    } beat_t;

    logic [PW_ROW_W-1:0] exp_mem [int];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [PW_ROW_W-1:0] obs,
                              input logic [PW_ROW_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed low word %0h expected low word %0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [PW_ROW_W-1:0] rand_row();
        logic [PW_ROW_W-1:0] d;
        for (int k = 0; k < PW_ROW_W / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic load_row(input int idx, input logic [PW_ROW_W-1:0] d);
        ld_valid = 1'b1;
        ld_index = IDX_W'(idx);
        ld_data  = d;
        settle();
        check("ld_ready", ld_ready, 1);
        check("ld_wr", mem_wr, (idx < HEIGHT) ? 1 : 0);
        if (idx < HEIGHT) begin
            check("ld_index", mem_index, idx);
            exp_mem[idx] = d;
        end
        next_cycle();
        ld_valid = 1'b0;
    endtask

    // mode 0: w_ready=1; mode 1: 1,0,0 repeating; mode 2: random.
    task automatic run_sweep(input int base, input int in_t, input int out_t,
                             input int mode, input bit hold_ld);
        beat_t exp_q[$];
        int    iss_q[$];
        beat_t b;
        bit    exp_err, done_seen, prev_stall;
        int    n, last_hs, first_iss, last_iss;
        logic  p_first, p_last;
        logic [TILE_W-1:0]   p_tile;
        logic [IDX_W-1:0]    p_index;
        logic [PW_ROW_W-1:0] p_data, hold_d;

        n       = in_t * out_t;
        exp_err = (in_t == 0) || (out_t == 0) || (base + n > HEIGHT);
        if (!exp_err) begin
            for (int o = 0; o < out_t; o++)
                for (int i = 0; i < in_t; i++) begin
                    b.row = base + o * in_t + i;
                    b.first = (i == 0);
                    b.last = (i == in_t - 1);
                    b.o = o;
                    exp_q.push_back(b);
                    iss_q.push_back(b.row);
                end
        end

        hold_d        = rand_row();
        start         = 1'b1;
        cfg_base      = IDX_W'(base);
        cfg_in_tiles  = TILE_W'(in_t);
        cfg_out_tiles = TILE_W'(out_t);
        w_ready       = 1'b1;
        if (hold_ld) begin
            ld_valid = 1'b1;
            ld_index = IDX_W'(50);
            ld_data  = hold_d;
        end
        settle();
        check("idle_busy", busy, 0);
        if (hold_ld) begin
            check("start_wins_ready", ld_ready, 0);
            check("start_wins_wr", mem_wr, 0);
        end

        next_cycle();
        start         = 1'b0;
        cfg_base      = IDX_W'($urandom);
        cfg_in_tiles  = TILE_W'($urandom);
        cfg_out_tiles = TILE_W'($urandom);
        settle();
        check("check_busy", busy, 1);
        check("check_err", err, exp_err ? 1 : 0);
        check("check_no_rd", mem_rd, 0);

        if (exp_err) begin
            next_cycle();
            settle();
            check("err_after_busy", busy, 0);
            check("err_after_err", err, 0);
            check("err_after_done", done, 0);
            check("err_after_valid", w_valid, 0);
            check("err_after_rd", mem_rd, 0);
            return;
        end

        done_seen = 0; prev_stall = 0; last_hs = -10; first_iss = -1; last_iss = -1;
        p_first = 0; p_last = 0; p_tile = '0; p_index = '0; p_data = '0;
        for (int cyc = 0; cyc < 500 && !done_seen; cyc++) begin
            next_cycle();
            case (mode)
                0:       w_ready = 1'b1;
                1:       w_ready = (cyc % 3 == 0);
                default: w_ready = 1'($urandom_range(0, 1));
            endcase
            settle();
            if (prev_stall) begin
                check("stall_valid", w_valid, 1);
                check("stall_first", w_first, p_first);
                check("stall_last", w_last, p_last);
                check("stall_tile", w_out_tile, p_tile);
                check_data("stall_data", mem_q, p_data);
                if (w_valid && !w_ready) check("stall_index", mem_index, p_index);
            end
            if (w_valid && !w_ready) check("stall_no_rd", mem_rd, 0);
            if (mem_rd) begin
                if (iss_q.size() == 0) check("extra_rd", mem_rd, 0);
                else begin
                    check("rd_index", mem_index, iss_q.pop_front());
                    if (first_iss < 0) first_iss = cyc;
                    last_iss = cyc;
                end
            end
            if (hold_ld && busy) begin
                check("busy_ld_ready", ld_ready, 0);
                check("busy_ld_wr", mem_wr, 0);
            end
            if (w_valid && w_ready) begin
                if (exp_q.size() == 0) check("extra_beat", w_valid, 0);
                else begin
                    b = exp_q.pop_front();
                    check("w_first", w_first, b.first);
                    check("w_last", w_last, b.last);
                    check("w_out_tile", w_out_tile, b.o);
                    check_data("w_data", mem_q, exp_mem[b.row]);
                    if (exp_q.size() == 0) last_hs = cyc;
                end
            end
            if (done) begin
                done_seen = 1;
                check("done_timing", cyc, last_hs + 1);
                check("done_busy", busy, 0);
                check("done_valid", w_valid, 0);
                if (hold_ld) begin
                    check("post_ld_ready", ld_ready, 1);
                    check("post_ld_wr", mem_wr, 1);
                    check("post_ld_index", mem_index, 50);
                end
            end else begin
                check("run_busy", busy, 1);
            end
            prev_stall = w_valid && !w_ready;
            p_first = w_first; p_last = w_last; p_tile = w_out_tile;
            p_index = mem_index; p_data = mem_q;
        end
        check("done_seen", done_seen, 1);
        check("beats_left", exp_q.size(), 0);
        check("issues_left", iss_q.size(), 0);
        if (mode == 0) check("issue_burst", last_iss - first_iss, n - 1);
        if (hold_ld) begin
            next_cycle();
            ld_valid = 1'b0;
            exp_mem[50] = hold_d;
        end
    endtask

    initial begin
        int beats, base, in_t, out_t;
        rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_in_tiles = '0; cfg_out_tiles = '0;
        ld_valid = 1'b0; ld_index = '0; ld_data = '0; w_ready = 1'b0;
        next_cycle();
        next_cycle();
        settle();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_valid", w_valid, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_mem_en", mem_en, 0);
        rst = 1'b0;
        next_cycle();

        // Load then sweep, plus an out-of-range load that must not write.
        for (int r = 100; r <= 105; r++) load_row(r, rand_row());
        load_row(HEIGHT, rand_row());
        run_sweep(100, 2, 3, 0, 0);
        // Backpressure 1,0,0,...
        run_sweep(100, 2, 3, 1, 0);
        // Range error: 930 + 9 = 939 > 938.
        run_sweep(930, 3, 3, 0, 0);
        // Zero config, then an immediately following valid sweep.
        run_sweep(100, 0, 3, 0, 0);
        run_sweep(100, 3, 2, 0, 0);
        // Arbitration: load held across the sweep, start wins in cycle 0.
        run_sweep(100, 2, 3, 0, 1);
        run_sweep(50, 1, 1, 0, 0);
        // Sweep ending exactly at the last row of the memory.
        for (int r = HEIGHT - 4; r < HEIGHT; r++) load_row(r, rand_row());
        run_sweep(HEIGHT - 4, 2, 2, 1, 0);
        // Randomized configs with random backpressure.
        for (int t = 0; t < 3; t++) begin
            base  = $urandom_range(200, 400);
            in_t  = $urandom_range(1, 4);
            out_t = $urandom_range(1, 3);
            for (int r = base; r < base + in_t * out_t; r++) load_row(r, rand_row());
            run_sweep(base, in_t, out_t, 2, 0);
        end

        // Reset mid-sweep after 3 beats.
        start = 1'b1; cfg_base = IDX_W'(100); cfg_in_tiles = TILE_W'(2); cfg_out_tiles = TILE_W'(3);
        w_ready = 1'b1;
        next_cycle();
        start = 1'b0;
        beats = 0;
        for (int cyc = 0; cyc < 50 && beats < 3; cyc++) begin
            next_cycle();
            settle();
            if (w_valid && w_ready) beats++;
        end
        check("rst_beats", beats, 3);
        rst = 1'b1;
        next_cycle();
        settle();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_valid", w_valid, 0);
        check("mid_rst_ld_ready", ld_ready, 0);
        check("mid_rst_en", mem_en, 0);
        check("mid_rst_rd", mem_rd, 0);
        check("mid_rst_wr", mem_wr, 0);
        check("mid_rst_index", mem_index, 0);
        check("mid_rst_first", w_first, 0);
        check("mid_rst_last", w_last, 0);
        check("mid_rst_tile", w_out_tile, 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            settle();
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
            check("post_rst_rd", mem_rd, 0);
        end
        load_row(0, rand_row());
        run_sweep(0, 1, 1, 0, 0);

        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/point_weights_rd_ctrl.md
Name: point_weights_rd_ctrl

Overview:
- Sequencer and arbiter for the 1x1 pointwise weight memory of a bneck stage. The memory is 938 rows; each row holds 16x16 signed 14-bit weights.
- Owns the memory's en/rd/wr/index pins and shares the memory between two requesters:
  - a weight-load port, used only while idle;
  - a layer read sweep that streams rows to the pointwise PE array under a valid/ready handshake.
- Memory data_out goes straight to the PE array. This block only qualifies it with w_valid and tags.

Parameters:
- DATA_WIDTH, 14, weight element width.
- ROW_ELEMS, 256, weights per memory row (16x16).
- HEIGHT, 938, memory depth in rows.
- IDX_W, 10, row index width.
- TILE_W, 6, tile counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; starts a sweep when idle.
- cfg_base  in  IDX_W  first row of the layer.
- cfg_in_tiles  in  TILE_W  16-channel input tiles per output tile.
- cfg_out_tiles  in  TILE_W  output tiles.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep completion.
- err  out  1  one-cycle pulse when a config is rejected.
- ld_valid  in  1  load request.
- ld_ready  out  1  load accepted this cycle.
- ld_index  in  IDX_W  load row.
- ld_data  in  DATA_WIDTH*ROW_ELEMS  load row data.
- mem_en  out  1  memory enable.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_index  out  IDX_W  memory row address.
- mem_data_in  out  DATA_WIDTH*ROW_ELEMS  write data, equal to ld_data.
- w_valid  out  1  memory data_out holds a valid row.
- w_ready  in  1  PE array accepts the row.
- w_first  out  1  row is the first input tile of its output tile.
- w_last  out  1  row is the last input tile of its output tile.
- w_out_tile  out  TILE_W  output-tile tag.

Behaviour:
- Memory contract: synchronous read, 1-cycle latency. data_out holds its last value while mem_rd=0.
- Reset (synchronous, active-high): on the clock edge where rst=1, go to IDLE and clear all counters. All outputs read 0 after that edge, including busy, done, err, w_valid and ld_ready.
  - Reset mid-sweep abandons the sweep with no done pulse.
- States: IDLE, CHECK, RUN, DRAIN.
- IDLE:
  - ld_ready = ld_valid.
  - When ld_valid=1: mem_en=1, mem_wr=1, mem_index=ld_index.
  - A load whose ld_index >= HEIGHT is still accepted but is not written (mem_wr=0).
  - start=1 latches cfg_* and moves to CHECK. start has priority over ld_valid in the same cycle; ld_ready=0 in that cycle.
- CHECK (1 cycle), busy=1:
  - Compute N = in_tiles*out_tiles.
  - If in_tiles=0, out_tiles=0, or base+N > HEIGHT: pulse err and go to IDLE with no reads and no done.
  - Otherwise go to RUN.
- RUN, busy=1, ld_ready=0:
  - issue = (rows_left>0) && (!w_valid || w_ready), combinational.
  - When issue=1: mem_en=1, mem_rd=1, mem_index=cursor.
  - Row order is out-major, in-minor: row = base + o*in_tiles + i.
  - Next cycle: w_valid=1, w_first=(i==0), w_last=(i==in_tiles-1), w_out_tile=o.
  - w_valid clears on w_ready only when no new issue occurred. Full throughput is 1 row/cycle while w_ready=1.
  - When rows_left reaches 0, go to DRAIN.
- DRAIN:
  - On the handshake of the final row, w_valid drops at the next edge and the block returns to IDLE.
  - done=1 for exactly that one cycle; busy=0 in the same cycle.
- start while busy is ignored; cfg changes while busy are ignored.
- ld_valid while busy: ld_ready=0; the requester holds.
- Stall: w_valid, tags and mem_index are stable while w_valid && !w_ready. No mem_rd is issued during the stall.
- Counter widths:
  - Product N uses 2*TILE_W bits.
  - base+N compare uses IDX_W+1 bits minimum, so there is no wrap.
  - Cursor never exceeds HEIGHT-1.

Decomposition:
- Shared package holds:
  - state encoding;
  - DATA_WIDTH, ROW_ELEMS and HEIGHT defaults;
  - the PW_ROW_W = DATA_WIDTH*ROW_ELEMS constant.
- One natural sub-module, pw_tile_counter: nested in/out tile counter producing cursor, first/last flags, o, and the final-row flag.

Test Plan:
- Load then sweep:
  - load rows 100..105 with distinct patterns, then start with base=100, in=2, out=3, w_ready=1;
  - expect mem_index 100..105 on consecutive cycles;
  - w_first on rows 100, 102, 104; w_last on 101, 103, 105; w_out_tile 0,0,1,1,2,2;
  - done 1 cycle after the last handshake.
- Backpressure:
  - same sweep with w_ready toggling 1,0,0,1,...;
  - expect no duplicated or skipped rows, and tags and data stable during stalls.
- Range error: base=930, in=3, out=3 (939 > 938) -> err pulse in the CHECK cycle, no mem_rd, no done, busy low afterwards.
- Zero config: in=0 -> err pulse; an immediately following valid start runs normally.
- Arbitration:
  - ld_valid held high during a sweep -> ld_ready=0 and mem_wr=0 throughout;
  - the load completes in the first IDLE cycle after done;
  - start and ld_valid in the same cycle -> start wins.
- Reset mid-sweep: rst=1 after 3 beats -> all outputs 0 after that edge, no done; a new start from base=0, in=1, out=1 -> single row 0 with w_first=w_last=1.
